// File: rtl/rr_priority_arbiter_pkg.sv
// Shared types, mode constants and sizing helper for the round-robin / fixed
// priority arbiter family.
package rr_priority_arbiter_pkg;

    // Arbiter control states.
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_e;

    // Arbitration modes selected through the RR_EN parameter.
    localparam int FIXED = 0;
    localparam int RR    = 1;

    // Width of a binary index into n lines, never less than one bit.
    function automatic int idx_width(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_priority_arbiter_if.sv
// Request/grant bundle between requesters (master) and the arbiter (slave).
interface rr_priority_arbiter_if
    import rr_priority_arbiter_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = idx_width(N)
);
    logic [N-1:0]     req;
    logic             ack;
    logic [N-1:0]     gnt;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;

    modport master (
        output req,
        output ack,
        input  gnt,
        input  gnt_idx,
        input  gnt_valid
    );

    modport slave (
        input  req,
        input  ack,
        output gnt,
        output gnt_idx,
        output gnt_valid
    );
endinterface

// File: rtl/rr_priority_arbiter_rot_priority_pick.sv
// Combinational pick: the first set request found descending from ptr,
// wrapping from 0 back to N-1. Done as rotate, MSB-first encode, un-rotate.
module rot_priority_pick
    import rr_priority_arbiter_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = idx_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] win_idx,
    output logic             any_req
);
    // One extra bit so ptr + offset (at most 2N-1) never overflows.
    localparam logic [IDX_W:0] N_EXT = (IDX_W + 1)'(N);

    logic [N-1:0]     rot;
    logic [IDX_W-1:0] rot_pos;
    logic [IDX_W:0]   unrot_sum;

    // Rotate so that req[ptr] lands on the MSB and req[ptr+1] on bit 0.
    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_rot
            logic [IDX_W:0] src_sum;
            logic [IDX_W:0] src_idx;
            assign src_sum = {1'b0, ptr} + (IDX_W + 1)'(gi + 1);
            assign src_idx = (src_sum >= N_EXT) ? (src_sum - N_EXT) : src_sum;
            assign rot[gi] = req[src_idx[IDX_W-1:0]];
        end
    endgenerate

    // MSB-first encode of the rotated vector (later iterations override).
    always_comb begin
        rot_pos = '0;
        for (int j = 0; j < N; j++) begin
            if (rot[j]) begin
                rot_pos = IDX_W'(j);
            end
        end
    end

    // Undo the rotation to recover the original request index.
    always_comb begin
        unrot_sum = {1'b0, ptr} + {1'b0, rot_pos} + (IDX_W + 1)'(1);
        win_idx   = (unrot_sum >= N_EXT) ? IDX_W'(unrot_sum - N_EXT)
                                         : unrot_sum[IDX_W-1:0];
    end

    assign any_req = |req;

endmodule

// File: rtl/rr_priority_arbiter.sv
// Registered N-way arbiter: grants one requester at a time, holds the grant
// until ack or request withdrawal, then idles one cycle before re-arbitrating.
module rr_priority_arbiter
    import rr_priority_arbiter_pkg::*;
#(
    parameter int N     = 8,
    parameter int IDX_W = idx_width(N),
    parameter int RR_EN = RR
) (
    input  logic                clk,
    input  logic                rst_n,
    rr_priority_arbiter_if.slave bus
);
    localparam logic [0:0]       S_IDLE   = IDLE;
    localparam logic [0:0]       S_GRANT  = GRANT;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    logic [0:0]       state_q,     state_d;
    logic [IDX_W-1:0] ptr_q,       ptr_d;
    logic [N-1:0]     gnt_q,       gnt_d;
    logic [IDX_W-1:0] gnt_idx_q,   gnt_idx_d;
    logic             gnt_valid_q, gnt_valid_d;

    logic [IDX_W-1:0] win_idx;
    logic             any_req;

    rot_priority_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (bus.req),
        .ptr     (ptr_q),
        .win_idx (win_idx),
        .any_req (any_req)
    );

    // Next-state: pick a winner from IDLE, release on ack or abandon in GRANT.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        gnt_d       = gnt_q;
        gnt_idx_d   = gnt_idx_q;
        gnt_valid_d = gnt_valid_q;
        case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    state_d     = S_GRANT;
                    gnt_d       = N'(1) << win_idx;
                    gnt_idx_d   = win_idx;
                    gnt_valid_d = 1'b1;
                end
            end
            S_GRANT: begin
                // ack and a dropped request in the same cycle are one release.
                if (bus.ack || !bus.req[gnt_idx_q]) begin
                    state_d     = S_IDLE;
                    gnt_d       = '0;
                    gnt_idx_d   = '0;
                    gnt_valid_d = 1'b0;
                    if (RR_EN == RR) begin
                        ptr_d = (gnt_idx_q == '0) ? LAST_IDX
                                                  : gnt_idx_q - IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d     = S_IDLE;
                gnt_d       = '0;
                gnt_idx_d   = '0;
                gnt_valid_d = 1'b0;
            end
        endcase
    end

    // State, pointer and output registers; reset clears the grant at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= LAST_IDX;
            gnt_q       <= '0;
            gnt_idx_q   <= '0;
            gnt_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            gnt_q       <= gnt_d;
            gnt_idx_q   <= gnt_idx_d;
            gnt_valid_q <= gnt_valid_d;
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.gnt_idx   = gnt_idx_q;
    assign bus.gnt_valid = gnt_valid_q;

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Bench for rr_priority_arbiter: three instances (fixed N=8, round-robin N=8,
// round-robin N=5) checked against a search-order reference model.
module tb_rr_priority_arbiter;

    logic clk;
    logic rst_n;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instance 0: fixed N=8, instance 1: RR N=8, instance 2: RR N=5.
    logic [7:0] req_v [3];
    logic        ack_v [3];

    rr_priority_arbiter_if #(.N(8)) if_f ();
    rr_priority_arbiter_if #(.N(8)) if_r ();
    rr_priority_arbiter_if #(.N(5)) if_5 ();

    assign if_f.req = req_v[0];
    assign if_r.req = req_v[1];
    assign if_5.req = req_v[2][4:0];
    assign if_f.ack = ack_v[0];
    assign if_r.ack = ack_v[1];
    assign if_5.ack = ack_v[2];

    rr_priority_arbiter #(.N(8), .RR_EN(0)) dut_f (.clk(clk), .rst_n(rst_n), .bus(if_f));
    rr_priority_arbiter #(.N(8), .RR_EN(1)) dut_r (.clk(clk), .rst_n(rst_n), .bus(if_r));
    rr_priority_arbiter #(.N(5), .RR_EN(1)) dut_5 (.clk(clk), .rst_n(rst_n), .bus(if_5));

    logic [7:0] obs_gnt   [3];
    logic [2:0] obs_idx   [3];
    logic       obs_valid [3];
    logic [2:0] obs_ptr   [3];

    assign obs_gnt[0]   = if_f.gnt;
    assign obs_gnt[1]   = if_r.gnt;
    assign obs_gnt[2]   = {3'b000, if_5.gnt};
    assign obs_idx[0]   = if_f.gnt_idx;
    assign obs_idx[1]   = if_r.gnt_idx;
    assign obs_idx[2]   = if_5.gnt_idx;
    assign obs_valid[0] = if_f.gnt_valid;
    assign obs_valid[1] = if_r.gnt_valid;
    assign obs_valid[2] = if_5.gnt_valid;
    assign obs_ptr[0]   = dut_f.ptr_q;
    assign obs_ptr[1]   = dut_r.ptr_q;
    assign obs_ptr[2]   = dut_5.ptr_q;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: grant flag, granted index, search start per instance.
    int n_of  [3] = '{8, 8, 5};
    int rr_of [3] = '{0, 1, 1};
    int m_valid [3];
    int m_idx   [3];
    int m_ptr   [3];

    // First requester met when counting down from p, wrapping 0 -> n-1.
    function automatic int pick(input logic [7:0] r, input int n, input int p);
        for (int k = 0; k < n; k++) begin
            int i;
            i = (p - k + n) % n;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_valid[k] = 0;
            m_idx[k]   = 0;
            m_ptr[k]   = n_of[k] - 1;
        end
    endtask

    // One clock: advance the model with the inputs sampled at this edge.
    task automatic cyc();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                m_valid[k] = 0;
                m_idx[k]   = 0;
                m_ptr[k]   = n_of[k] - 1;
            end else if (m_valid[k] == 0) begin
                int w;
                w = pick(req_v[k], n_of[k], m_ptr[k]);
                if (w >= 0) begin
                    m_valid[k] = 1;
                    m_idx[k]   = w;
                end
            end else if (ack_v[k] || !req_v[k][m_idx[k]]) begin
                m_valid[k] = 0;
                if (rr_of[k] != 0) m_ptr[k] = (m_idx[k] + n_of[k] - 1) % n_of[k];
                m_idx[k] = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_v[k] = '0;
            ack_v[k] = 1'b0;
        end
        cyc();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_v[k] = 8'hFF;
            ack_v[k] = 1'b0;
        end
        repeat (2) begin
            cyc();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs_gnt[k] !== 8'h00 || obs_idx[k] !== 3'd0 || obs_valid[k] !== 1'b0) begin
                    miscompares++;
                    $display("FAIL reset_hold inst%0d: gnt=%h idx=%0d valid=%b want 00/0/0",
                             k, obs_gnt[k], obs_idx[k], obs_valid[k]);
                end
            end
        end
        rst_n = 1'b1;
        cyc();
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (obs_valid[k] !== 1'b1 || obs_idx[k] !== 3'(n_of[k] - 1)) begin
                miscompares++;
                $display("FAIL reset_first_grant inst%0d: idx=%0d valid=%b want %0d/1",
                         k, obs_idx[k], obs_valid[k], n_of[k] - 1);
            end
        end
        // Assert reset away from any clock edge while grants are held.
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (obs_gnt[k] !== 8'h00 || obs_idx[k] !== 3'd0 || obs_valid[k] !== 1'b0
                || obs_ptr[k] !== 3'(n_of[k] - 1)) begin
                miscompares++;
                $display("FAIL reset_async inst%0d: gnt=%h idx=%0d valid=%b ptr=%0d want 00/0/0/%0d",
                         k, obs_gnt[k], obs_idx[k], obs_valid[k], obs_ptr[k], n_of[k] - 1);
            end
        end
        #1;
        rst_n = 1'b1;
        cyc();
        vectors++;
        if (obs_idx[1] !== 3'd7 || obs_valid[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_regrant: idx=%0d valid=%b want 7/1", obs_idx[1], obs_valid[1]);
        end
        $display("test_reset done");
    endtask

    task automatic test_fixed();
        do_reset();
        req_v[0] = 8'b0000_1010;
        cyc();
        vectors++;
        if (obs_gnt[0] !== 8'b0000_1000 || obs_idx[0] !== 3'd3 || obs_valid[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL fixed_first: gnt=%b idx=%0d valid=%b want 00001000/3/1",
                     obs_gnt[0], obs_idx[0], obs_valid[0]);
        end
        ack_v[0] = 1'b1;
        cyc();
        ack_v[0] = 1'b0;
        vectors++;
        if (obs_valid[0] !== 1'b0 || obs_gnt[0] !== 8'h00) begin
            miscompares++;
            $display("FAIL fixed_bubble: gnt=%b valid=%b want 0/0", obs_gnt[0], obs_valid[0]);
        end
        cyc();
        vectors++;
        if (obs_idx[0] !== 3'd3 || obs_valid[0] !== 1'b1 || obs_ptr[0] !== 3'd7) begin
            miscompares++;
            $display("FAIL fixed_regrant: idx=%0d valid=%b ptr=%0d want 3/1/7",
                     obs_idx[0], obs_valid[0], obs_ptr[0]);
        end
        req_v[0] = 8'b0101_0000;
        cyc();
        cyc();
        vectors++;
        if (obs_idx[0] !== 3'd6 || obs_gnt[0] !== 8'b0100_0000) begin
            miscompares++;
            $display("FAIL fixed_msb: idx=%0d gnt=%b want 6/01000000", obs_idx[0], obs_gnt[0]);
        end
        $display("test_fixed done");
    endtask

    task automatic run_rr_seq(input logic [7:0] r, input int e_idx [4], input int e_ptr [4]);
        do_reset();
        req_v[1] = r;
        for (int g = 0; g < 4; g++) begin
            cyc();
            vectors++;
            if (obs_idx[1] !== 3'(e_idx[g]) || obs_valid[1] !== 1'b1) begin
                miscompares++;
                $display("FAIL rr_idx req=%b grant%0d: idx=%0d valid=%b want %0d/1",
                         r, g, obs_idx[1], obs_valid[1], e_idx[g]);
            end
            ack_v[1] = 1'b1;
            cyc();
            ack_v[1] = 1'b0;
            vectors++;
            if (obs_ptr[1] !== 3'(e_ptr[g]) || obs_valid[1] !== 1'b0) begin
                miscompares++;
                $display("FAIL rr_ptr req=%b grant%0d: ptr=%0d valid=%b want %0d/0",
                         r, g, obs_ptr[1], obs_valid[1], e_ptr[g]);
            end
        end
    endtask

    task automatic test_round_robin();
        run_rr_seq(8'b0101_0000, '{6, 4, 6, 4}, '{5, 3, 5, 3});
        run_rr_seq(8'b1000_0001, '{7, 0, 7, 0}, '{6, 7, 6, 7});
        $display("test_round_robin done");
    endtask

    task automatic test_hold_no_preempt();
        do_reset();
        req_v[1] = 8'b0000_0100;
        cyc();
        req_v[1] = 8'b1000_0100;
        for (int c = 0; c < 10; c++) begin
            cyc();
            vectors++;
            if (obs_gnt[1] !== 8'b0000_0100 || obs_idx[1] !== 3'd2) begin
                miscompares++;
                $display("FAIL hold cycle%0d: gnt=%b idx=%0d want 00000100/2",
                         c, obs_gnt[1], obs_idx[1]);
            end
        end
        ack_v[1] = 1'b1;
        cyc();
        ack_v[1] = 1'b0;
        vectors++;
        if (obs_valid[1] !== 1'b0 || obs_ptr[1] !== 3'd1) begin
            miscompares++;
            $display("FAIL hold_release: valid=%b ptr=%0d want 0/1", obs_valid[1], obs_ptr[1]);
        end
        cyc();
        vectors++;
        if (obs_idx[1] !== 3'd7 || obs_valid[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL hold_next: idx=%0d valid=%b want 7/1", obs_idx[1], obs_valid[1]);
        end
        $display("test_hold_no_preempt done");
    endtask

    task automatic test_abandon();
        do_reset();
        req_v[1] = 8'b0001_0000;
        cyc();
        vectors++;
        if (obs_idx[1] !== 3'd4 || obs_valid[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL abandon_grant: idx=%0d valid=%b want 4/1", obs_idx[1], obs_valid[1]);
        end
        req_v[1] = 8'b0000_0000;
        cyc();
        vectors++;
        if (obs_valid[1] !== 1'b0 || obs_ptr[1] !== 3'd3) begin
            miscompares++;
            $display("FAIL abandon_release: valid=%b ptr=%0d want 0/3", obs_valid[1], obs_ptr[1]);
        end
        req_v[1] = 8'b0001_1000;
        cyc();
        vectors++;
        if (obs_idx[1] !== 3'd3 || obs_valid[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL abandon_next: idx=%0d valid=%b want 3/1", obs_idx[1], obs_valid[1]);
        end
        $display("test_abandon done");
    endtask

    task automatic test_random_soak();
        logic [7:0] exp_gnt;
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int k = 0; k < 3; k++) begin
                if ($urandom_range(3) == 0) req_v[k] = 8'($urandom) & ((k == 2) ? 8'h1F : 8'hFF);
                ack_v[k] = ($urandom_range(3) == 0);
            end
            cyc();
            for (int k = 0; k < 3; k++) begin
                exp_gnt = (m_valid[k] != 0) ? (8'd1 << m_idx[k]) : 8'd0;
                vectors++;
                if (obs_valid[k] !== 1'(m_valid[k]) || obs_idx[k] !== 3'(m_idx[k])
                    || obs_gnt[k] !== exp_gnt || obs_ptr[k] !== 3'(m_ptr[k])) begin
                    miscompares++;
                    $display("FAIL soak_model inst%0d cyc%0d: gnt=%b idx=%0d valid=%b ptr=%0d want %b/%0d/%0d/%0d",
                             k, c, obs_gnt[k], obs_idx[k], obs_valid[k], obs_ptr[k],
                             exp_gnt, m_idx[k], m_valid[k], m_ptr[k]);
                end
                vectors++;
                if ($countones(obs_gnt[k]) > 1 || obs_valid[k] !== (|obs_gnt[k])
                    || (obs_valid[k] && obs_gnt[k] !== (8'd1 << obs_idx[k]))) begin
                    miscompares++;
                    $display("FAIL soak_invariant inst%0d cyc%0d: gnt=%b idx=%0d valid=%b",
                             k, c, obs_gnt[k], obs_idx[k], obs_valid[k]);
                end
            end
        end
        $display("test_random_soak done");
    endtask

    task automatic test_fairness();
        int waits [3][8];
        logic prev_valid [3];
        do_reset();
        for (int k = 0; k < 3; k++) begin
            req_v[k] = (k == 2) ? 8'h1F : 8'hFF;
            prev_valid[k] = 1'b0;
            for (int i = 0; i < 8; i++) waits[k][i] = 0;
        end
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 3; k++) ack_v[k] = ($urandom_range(1) == 1);
            cyc();
            for (int k = 1; k < 3; k++) begin
                if (obs_valid[k] === 1'b1 && !prev_valid[k]) begin
                    for (int i = 0; i < n_of[k]; i++) begin
                        if (i == int'(obs_idx[k])) waits[k][i] = 0;
                        else waits[k][i]++;
                    end
                    for (int i = 0; i < n_of[k]; i++) begin
                        vectors++;
                        if (waits[k][i] > n_of[k]) begin
                            miscompares++;
                            $display("FAIL fairness inst%0d req%0d: waited %0d grants, want <= %0d",
                                     k, i, waits[k][i], n_of[k]);
                        end
                    end
                end
                prev_valid[k] = obs_valid[k];
            end
        end
        $display("test_fairness done");
    endtask

    initial begin
        rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            req_v[k] = '0;
            ack_v[k] = 1'b0;
        end
        model_reset();
        test_reset();
        test_fixed();
        test_round_robin();
        test_hold_no_preempt();
        test_abandon();
        test_random_soak();
        test_fairness();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
